// File: rtl/ws2812_multi_driver_pkg.sv
// Shared state encoding and timing-constant helpers for the WS2812 multi-channel driver.
package ws2812_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Ceiling log2, never below 1 so that single-entry counters still get a bit.
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int cycle_len(input int sys_clk, input int rate);
    return sys_clk / rate;
  endfunction

  function automatic int high_time(input int sys_clk, input int ns);
    return sys_clk / 1000 * ns / 1_000_000;
  endfunction

  function automatic int latch_len(input int sys_clk, input int us);
    return sys_clk / 1_000_000 * us;
  endfunction

endpackage

// File: rtl/ws2812_multi_driver_if.sv
// Pixel-memory read port: the driver is master, the memory answers one cycle after pix_req.
interface ws2812_multi_driver_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 96
) ();
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_req;
  logic [DATA_W-1:0] pix_data;

  modport master (output pix_addr, output pix_req, input pix_data);
  modport slave  (input pix_addr, input pix_req, output pix_data);
endinterface

// File: rtl/ws2812_multi_driver_bit_timer.sv
// Shared bit-period counter: one count per bit, with per-channel high-phase compare.
module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CYCLE        = 62,
  parameter int T0H          = 17,
  parameter int T1H          = 35
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic [NUM_CHANNELS-1:0] msb,
  output logic                    bit_start,
  output logic                    bit_end,
  output logic [NUM_CHANNELS-1:0] high
);

  localparam int CW = log2(CYCLE);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset_n || !run) begin
      cnt_reg <= '0;
    end else if (bit_end) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bit_start = run && (cnt_reg == '0);
  assign bit_end   = run && (cnt_reg == CW'(CYCLE - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_cmp
      assign high[gi] = run && (cnt_reg < (msb[gi] ? CW'(T1H) : CW'(T0H)));
    end
  endgenerate

endmodule

// File: rtl/ws2812_multi_driver.sv
// Lockstep WS2812 driver for NUM_CHANNELS strips with gap-free pixel prefetch.
// Optional per-field brightness scaling is enabled by defining WS2812_BRIGHTNESS_EN.
module ws2812_multi_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_CHANNELS     = 4,
  parameter int LEDS_PER_CHANNEL = 5,
  parameter int BITS_PER_LED     = 24,
  parameter int SYSTEM_CLOCK     = 50_000_000,
  parameter int BIT_RATE         = 800_000,
  parameter int T0H_NS           = 350,
  parameter int T1H_NS           = 700,
  parameter int RESET_US         = 80
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    continuous,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]              brightness,
`endif
  ws2812_multi_driver_if.master   pix,
  output logic [NUM_CHANNELS-1:0] ws_out,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int CYCLE = cycle_len(SYSTEM_CLOCK, BIT_RATE);
  localparam int T0H   = high_time(SYSTEM_CLOCK, T0H_NS);
  localparam int T1H   = high_time(SYSTEM_CLOCK, T1H_NS);
  localparam int RST   = latch_len(SYSTEM_CLOCK, RESET_US);
  localparam int CW    = log2(RST);
  localparam int BW    = log2(BITS_PER_LED);
  localparam int AW    = log2(LEDS_PER_CHANNEL);
  localparam int DW    = NUM_CHANNELS * BITS_PER_LED;

  logic [1:0]              state_reg;
  logic [CW-1:0]           cnt_reg;
  logic [BW-1:0]           bit_reg;
  logic [AW-1:0]           led_reg;
  logic [AW-1:0]           addr_reg;
  logic                    valid_reg;
  logic                    req;
  logic                    cap;
  logic                    latch_end;
  logic                    led_end;
  logic                    bit_start;
  logic                    bit_end;
  logic [NUM_CHANNELS-1:0] msb;
  logic [NUM_CHANNELS-1:0] high;
  logic [DW-1:0]           load_data;

  assign latch_end = (state_reg == ST_LATCH) && (cnt_reg == CW'(RST - 1));
  assign led_end   = bit_end && (bit_reg == BW'(BITS_PER_LED - 1));

`ifdef WS2812_BRIGHTNESS_EN
  // Requests lead by one cycle to cover the scaling register stage.
  assign req = ((state_reg == ST_LATCH) && (cnt_reg == CW'(RST - 3)))
            || (latch_end && (LEDS_PER_CHANNEL > 1))
            || (led_end && (int'(led_reg) < LEDS_PER_CHANNEL - 2));

  logic [DW-1:0] scaled;
  logic [DW-1:0] scaled_reg;
  logic          cap_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DW / 8; gi++) begin : g_scale
      logic [15:0] prod;
      assign prod = 16'(pix.pix_data[gi*8 +: 8]) * 16'(brightness);
      assign scaled[gi*8 +: 8] = prod[15:8];
    end
  endgenerate

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      scaled_reg <= '0;
      cap_reg    <= 1'b0;
    end else begin
      scaled_reg <= scaled;
      cap_reg    <= valid_reg;
    end
  end

  assign load_data = scaled_reg;
  assign cap       = cap_reg;
`else
  assign req = ((state_reg == ST_LATCH) && (cnt_reg == CW'(RST - 2)))
            || (bit_start && (bit_reg == '0) && (led_reg != AW'(LEDS_PER_CHANNEL - 1)));

  assign load_data = pix.pix_data;
  assign cap       = valid_reg;

  genvar gi;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      led_reg   <= '0;
      addr_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= req;
      // Address saturates at the last LED so it never wraps inside a frame.
      if (req && (addr_reg != AW'(LEDS_PER_CHANNEL - 1))) addr_reg <= addr_reg + 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (start || continuous) begin
            state_reg <= ST_LATCH;
            cnt_reg   <= '0;
            addr_reg  <= '0;
          end
        end
        ST_LATCH: begin
          if (latch_end) begin
            state_reg <= ST_SHIFT;
            bit_reg   <= '0;
            led_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bit_end) begin
            if (bit_reg == BW'(BITS_PER_LED - 1)) begin
              bit_reg <= '0;
              if (led_reg == AW'(LEDS_PER_CHANNEL - 1)) state_reg <= ST_DONE;
              else                                      led_reg   <= led_reg + 1'b1;
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (continuous) begin
            state_reg <= ST_LATCH;
            cnt_reg   <= '0;
            addr_reg  <= '0;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      logic [BITS_PER_LED-1:0] shift_reg;
      logic [BITS_PER_LED-1:0] shadow_reg;

      always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
          shift_reg  <= '0;
          shadow_reg <= '0;
        end else begin
          if (cap) shadow_reg <= load_data[gi*BITS_PER_LED +: BITS_PER_LED];
          if (latch_end)    shift_reg <= load_data[gi*BITS_PER_LED +: BITS_PER_LED];
          else if (led_end) shift_reg <= shadow_reg;
          else if (bit_end) shift_reg <= {shift_reg[BITS_PER_LED-2:0], 1'b0};
        end
      end

      assign msb[gi] = shift_reg[BITS_PER_LED-1];
    end
  endgenerate

  ws2812_bit_timer #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CYCLE        (CYCLE),
    .T0H          (T0H),
    .T1H          (T1H)
  ) u_bit_timer (
    .clk       (CLOCK_50),
    .reset_n   (reset_n),
    .run       (state_reg == ST_SHIFT),
    .msb       (msb),
    .bit_start (bit_start),
    .bit_end   (bit_end),
    .high      (high)
  );

  assign pix.pix_req  = req;
  assign pix.pix_addr = addr_reg;
  assign ws_out       = high;
  assign busy         = (state_reg != ST_IDLE);
  assign frame_done   = (state_reg == ST_DONE);

endmodule
